rf_shot_sequencer: RTL and testbench
====================================

// Module: rf_shot_sequencer
// PURPOSE
//  Sequences one rangefinder shot: fires the laser trigger, opens a timed listen window,
//  timestamps synchronized comparator hits and requests a comparator re-arm after each hit.
//  The block sits between the host/measurement control and comp_reset_generator.
//  It produces per-hit time-of-flight samples in ref_clk ticks and ends with a done summary.
// PARAMETERS
//  TW          16    width of the time counter and timestamps; 2**TW > WINDOW_LEN
//  LASER_LEN   4     laser_trig high time, in cycles
//  BLANK_LEN   10    blanking cycles after the laser pulse; hits ignored (SEQ_BLANKING_EN only)
//  WINDOW_LEN  1000  listen window length, counted from the first FIRE cycle
//  HOLDOFF     26    cycles hits are ignored after a re-arm request; must be >= PULSE_DELAY+PULSE_LEN+2
//  MAX_HITS    4     maximum hits per shot, >= 1
// PORTS
//  ref_clk      in   1              clock
//  reset        in   1              reset, synchronous, active-high
//  start        in   1              shot request pulse; ignored while busy
//  comp_hit     in   1              comparator hit, single-cycle pulse, already in the ref_clk domain
//  laser_trig   out  1              laser fire pulse
//  comp_rst_req out  1              1-cycle re-arm request to the comparator reset generator
//  busy         out  1              high from the accepted start until done
//  hit_valid    out  1              1-cycle strobe; hit_time/hit_idx are valid with it
//  hit_time     out  TW             time counter value on the hit cycle
//  hit_idx      out  clog2(MAX_HITS) index of the hit within the shot, starting at 0
//  done         out  1              1-cycle strobe at end of shot
//  hit_count    out  clog2(MAX_HITS+1) number of hits; held from done until the next start
//  no_echo      out  1              high with done when hit_count==0; held with hit_count
// BEHAVIOUR
//  Reset: every output is 0 and the state is IDLE. Reset mid-shot drops laser_trig at the
//   same edge; no done is issued.
//  Time counter tcnt:
//   - cleared on the accepted start;
//   - increments every cycle in FIRE/BLANK/LISTEN/RECOVER;
//   - the cycle after start sees tcnt=0.
//  win_end = (tcnt == WINDOW_LEN-1).
//  States:
//   - IDLE: on start, go to FIRE. busy=1, hit_count and no_echo clear, laser_trig=1 from the next cycle.
//   - FIRE: laser_trig=1 for exactly LASER_LEN cycles. Hits are ignored.
//     Then go to BLANK (macro defined) or to LISTEN.
//   - BLANK: lasts BLANK_LEN cycles, then go to LISTEN. Hits are ignored.
//   - LISTEN, on comp_hit:
//     - hit_valid=1 on the next cycle, with hit_time = tcnt of the hit cycle and hit_idx = the current count;
//     - comp_rst_req=1 for that same cycle;
//     - count increments; go to RECOVER.
//     - A hit on the win_end cycle is accepted.
//   - LISTEN, win_end without a hit: go to DONE.
//   - RECOVER: hits are ignored for HOLDOFF cycles, then go back to LISTEN.
//     - If win_end occurs in RECOVER, go to DONE.
//     - If count == MAX_HITS after the hit, go to DONE instead of RECOVER; comp_rst_req is still issued.
//   - DONE: done=1 for one cycle, busy drops with it, and hit_count/no_echo are updated. Go to IDLE.
//  Arithmetic: tcnt does not wrap; WINDOW_LEN <= 2**TW is enforced by an elaboration check.
//  Simultaneous events: start together with done is ignored; start in IDLE is taken on the cycle after done.
//  Latency: start to laser_trig rise is 1 cycle; comp_hit to hit_valid is 1 cycle.
// CONFIGURATION
//  SEQ_BLANKING_EN
//   - Defined: the BLANK state exists and suppresses near-field scatter for BLANK_LEN cycles after FIRE.
//   - Undefined: FIRE goes straight to LISTEN; BLANK_LEN is unused.
//     Hits are accepted from tcnt=LASER_LEN.
// STRUCTURE
//  Shared package rf_pkg:
//   - state encoding constants ST_IDLE, ST_FIRE, ST_BLANK, ST_LISTEN, ST_RECOVER, ST_DONE;
//   - the HOLDOFF minimum relation to the comp_reset_generator PULSE_DELAY/PULSE_LEN.
//  Sub-module rf_dwell_counter: loadable down-counter with a zero flag.
//   Shared by the FIRE, BLANK and RECOVER dwell times. tcnt stays inline.
// TESTING
//  1. start, no hits, defaults -> laser_trig high 4 cycles; done after tcnt=999; hit_count=0, no_echo=1.
//  2. comp_hit at tcnt=300 -> hit_valid next cycle, hit_time=300, hit_idx=0, comp_rst_req 1 cycle.
//     Second hit at tcnt=310 is ignored; hit at tcnt=400 gives hit_idx=1. done with hit_count=2.
//  3. Hits at tcnt=50, 100, 150, 200, 250 with HOLDOFF=26 -> four hit_valid strobes.
//     done right after hit 3; hit_count=4; the tcnt=250 hit is ignored.
//  4. Macro defined, hit at tcnt=8 -> ignored (blanked); hit at tcnt=14 is accepted.
//     Macro undefined: the tcnt=8 hit is accepted.
//  5. Hit exactly at tcnt=999 -> accepted with hit_time=999, then done.
//     A start pulse during busy has no effect.
//  6. reset asserted while laser_trig is high -> all outputs 0 next cycle, state IDLE, no done.
//     A subsequent start runs a clean shot.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and constants for the rangefinder shot sequencer.
// Ties the re-arm holdoff to the comparator reset generator pulse timing.
package rf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRE,
    ST_BLANK,
    ST_LISTEN,
    ST_RECOVER,
    ST_DONE
  } rf_state_t;

  localparam int CRG_PULSE_DELAY = 16;
  localparam int CRG_PULSE_LEN   = 8;
  localparam int HOLDOFF_MIN     = CRG_PULSE_DELAY + CRG_PULSE_LEN + 2;

  function automatic bit holdoff_ok(input int h);
    return h >= HOLDOFF_MIN;
  endfunction

endpackage

// File: rtl/rf_shot_sequencer_dwell.sv
// rf_dwell_counter: loadable down-counter with zero flag.
// Times the FIRE, BLANK and RECOVER dwells of the shot sequencer.
module rf_dwell_counter #(
  parameter int W = 16
) (
  input  logic         ref_clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge ref_clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/rf_shot_sequencer.sv
// Rangefinder shot sequencer: laser fire, listen window, hit timestamps.
// Optional SEQ_BLANKING_EN adds a BLANK dwell after the laser pulse.
module rf_shot_sequencer
  import rf_pkg::*;
#(
  parameter int TW         = 16,
  parameter int LASER_LEN  = 4,
  parameter int BLANK_LEN  = 10,
  parameter int WINDOW_LEN = 1000,
  parameter int HOLDOFF    = 26,
  parameter int MAX_HITS   = 4,
  localparam int IW = (MAX_HITS > 1) ? $clog2(MAX_HITS) : 1,
  localparam int CW = $clog2(MAX_HITS + 1)
) (
  input  logic          ref_clk,
  input  logic          reset,
  input  logic          start,
  input  logic          comp_hit,
  output logic          laser_trig,
  output logic          comp_rst_req,
  output logic          busy,
  output logic          hit_valid,
  output logic [TW-1:0] hit_time,
  output logic [IW-1:0] hit_idx,
  output logic          done,
  output logic [CW-1:0] hit_count,
  output logic          no_echo
);

  if (longint'(WINDOW_LEN) > (longint'(1) << TW)) begin : g_win_chk
    $error("WINDOW_LEN does not fit in TW bits");
  end
  if (!holdoff_ok(HOLDOFF)) begin : g_hold_chk
    $error("HOLDOFF shorter than comparator re-arm pulse");
  end

  rf_state_t     state, state_n;
  logic [TW-1:0] tcnt;
  logic [CW-1:0] count, cnt_n;
  logic          dw_load, dw_en, dw_zero;
  logic [TW-1:0] dw_val;
  logic          accept_hit;
  logic          win_end;
  logic          active;

  assign win_end = (tcnt == TW'(WINDOW_LEN - 1));
  assign active  = (state == ST_FIRE) || (state == ST_BLANK) ||
                   (state == ST_LISTEN) || (state == ST_RECOVER);

  rf_dwell_counter #(.W(TW)) u_dwell (
    .ref_clk  (ref_clk),
    .reset    (reset),
    .load     (dw_load),
    .load_val (dw_val),
    .en       (dw_en),
    .zero     (dw_zero)
  );

  always_comb begin
    state_n    = state;
    dw_load    = 1'b0;
    dw_val     = '0;
    dw_en      = 1'b0;
    accept_hit = 1'b0;
    cnt_n      = count;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_FIRE;
          dw_load = 1'b1;
          dw_val  = TW'(LASER_LEN - 1);
        end
      end
      ST_FIRE: begin
        dw_en = 1'b1;
        if (dw_zero) begin
`ifdef SEQ_BLANKING_EN
          state_n = ST_BLANK;
          dw_load = 1'b1;
          dw_val  = TW'(BLANK_LEN - 1);
`else
          state_n = ST_LISTEN;
`endif
        end
      end
      ST_BLANK: begin
        dw_en = 1'b1;
        if (dw_zero)
          state_n = ST_LISTEN;
      end
      ST_LISTEN: begin
        if (comp_hit) begin
          accept_hit = 1'b1;
          cnt_n      = count + 1'b1;
          if (cnt_n == CW'(MAX_HITS) || win_end) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_RECOVER;
            dw_load = 1'b1;
            dw_val  = TW'(HOLDOFF - 1);
          end
        end else if (win_end) begin
          state_n = ST_DONE;
        end
      end
      ST_RECOVER: begin
        dw_en = 1'b1;
        if (win_end)
          state_n = ST_DONE;
        else if (dw_zero)
          state_n = ST_LISTEN;
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      tcnt         <= '0;
      count        <= '0;
      hit_valid    <= 1'b0;
      comp_rst_req <= 1'b0;
      hit_time     <= '0;
      hit_idx      <= '0;
      hit_count    <= '0;
      no_echo      <= 1'b0;
    end else begin
      state        <= state_n;
      hit_valid    <= accept_hit;
      comp_rst_req <= accept_hit;
      count        <= cnt_n;
      if (accept_hit) begin
        hit_time <= tcnt;
        hit_idx  <= IW'(count);
      end
      if (state == ST_IDLE && start) begin
        tcnt      <= '0;
        count     <= '0;
        hit_count <= '0;
        no_echo   <= 1'b0;
      end else if (active) begin
        tcnt <= tcnt + 1'b1;
      end
      // summary is published as DONE is entered so it is valid with done
      if (state_n == ST_DONE && state != ST_DONE) begin
        hit_count <= cnt_n;
        no_echo   <= (cnt_n == '0);
      end
    end
  end

  assign laser_trig = (state == ST_FIRE);
  assign busy       = active;
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_rf_shot_sequencer.sv
// Scoreboard bench for rf_shot_sequencer with directed shots.
// Expectations follow SEQ_BLANKING_EN when the macro is defined.
module tb_rf_shot_sequencer;

  logic        ref_clk = 1'b0;
  logic        reset;
  logic        start;
  logic        comp_hit;
  logic        laser_trig;
  logic        comp_rst_req;
  logic        busy;
  logic        hit_valid;
  logic [15:0] hit_time;
  logic [1:0]  hit_idx;
  logic        done;
  logic [2:0]  hit_count;
  logic        no_echo;

  rf_shot_sequencer dut (
    .ref_clk      (ref_clk),
    .reset        (reset),
    .start        (start),
    .comp_hit     (comp_hit),
    .laser_trig   (laser_trig),
    .comp_rst_req (comp_rst_req),
    .busy         (busy),
    .hit_valid    (hit_valid),
    .hit_time     (hit_time),
    .hit_idx      (hit_idx),
    .done         (done),
    .hit_count    (hit_count),
    .no_echo      (no_echo)
  );

  always #5 ref_clk = ~ref_clk;

  typedef struct {
    int t;
    int idx;
  } hexp_t;

  hexp_t hq[$];
  int    dq[$];
  int    stim[$];
  int    expt[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    laser_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge ref_clk) begin
    if (laser_trig)
      laser_cnt++;
    if (hit_valid) begin
      if (hq.size() == 0) begin
        chk("unexpected_hit", int'(hit_time), -1);
      end else begin
        hexp_t e;
        e = hq.pop_front();
        chk("hit_time", int'(hit_time), e.t);
        chk("hit_idx", int'(hit_idx), e.idx);
        chk("comp_rst_req", int'(comp_rst_req), 1);
      end
    end else if (comp_rst_req) begin
      chk("stray_rst_req", 1, 0);
    end
    if (done) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        int c;
        c = dq.pop_front();
        chk("done_hit_count", int'(hit_count), c);
        chk("done_no_echo", int'(no_echo), (c == 0) ? 1 : 0);
        chk("done_busy", int'(busy), 0);
      end
    end
  end

  task automatic cyc();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic run_shot(input int exp_cnt, input int restart_at);
    for (int i = 0; i < expt.size(); i++) begin
      hexp_t e;
      e.t = expt[i];
      e.idx = i;
      hq.push_back(e);
    end
    dq.push_back(exp_cnt);
    laser_cnt = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("laser_rise", int'(laser_trig), 1);
    for (int t = 0; t <= 1005; t++) begin
      comp_hit = 1'b0;
      foreach (stim[k])
        if (stim[k] == t)
          comp_hit = 1'b1;
      start = (t == restart_at);
      if (t == restart_at)
        chk("busy_mid_shot", int'(busy), 1);
      cyc();
    end
    comp_hit = 1'b0;
    start = 1'b0;
    repeat (3) cyc();
    chk("laser_len", laser_cnt, 4);
    chk("held_hit_count", int'(hit_count), exp_cnt);
    chk("queues_drained", hq.size() + dq.size(), 0);
    hq.delete();
    dq.delete();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    comp_hit = 1'b0;
    repeat (3) cyc();
    chk("rst_laser", int'(laser_trig), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    chk("rst_no_echo", int'(no_echo), 0);
    reset = 1'b0;
    repeat (2) cyc();

    // 1: no echo
    stim.delete();
    expt.delete();
    run_shot(0, -1);

    // 2: second hit inside holdoff is dropped
    stim = {300, 310, 400};
    expt = {300, 400};
    run_shot(2, -1);

    // 3: MAX_HITS cap
    stim = {50, 100, 150, 200, 250};
    expt = {50, 100, 150, 200};
    run_shot(4, -1);

    // 4: near-field blanking
    stim = {8, 14};
`ifdef SEQ_BLANKING_EN
    expt = {14};
`else
    expt = {8};
`endif
    run_shot(1, -1);

    // 5: hit on the last window cycle, start while busy
    stim = {999};
    expt = {999};
    run_shot(1, 500);

    // 6: reset while the laser fires
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("pre_rst_laser", int'(laser_trig), 1);
    reset = 1'b1;
    cyc();
    chk("midrst_laser", int'(laser_trig), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_hit_valid", int'(hit_valid), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_rst_req", int'(comp_rst_req), 0);
    reset = 1'b0;
    repeat (5) cyc();
    stim.delete();
    expt.delete();
    run_shot(0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
